// File: rtl/conv_pkg.sv
// Geometry and width constants shared by the conv engine and its post-processing stages.
package conv_pkg;
  localparam int IMG_W_IN  = 32;
  localparam int KERNEL    = 5;
  localparam int CONV_W    = IMG_W_IN - KERNEL + 1;
  localparam int BW_ACT    = 8;
  localparam int BW_CONV   = 16;
  localparam int POOL      = 2;
  localparam int REQ_SHIFT = 4;
endpackage

// File: rtl/relu_maxpool2x2_if.sv
// Stream bundle between the conv engine output and the pooling stage output.
interface relu_maxpool2x2_if #(
  parameter int BW_IN  = 16,
  parameter int BW_OUT = 8
);
  logic                     valid;
  logic signed [BW_IN-1:0]  y;
  logic                     ovalid;
  logic signed [BW_OUT-1:0] p;
  logic                     frame_done;

  modport master (output valid, y, input ovalid, p, frame_done);
  modport slave  (input valid, y, output ovalid, p, frame_done);
endinterface

// File: rtl/pool_linebuf.sv
// One pooled-row line buffer: synchronous write, combinational read, no reset.
module pool_linebuf #(
  parameter int DEPTH = 14,
  parameter int DW    = 15,
  parameter int AW    = 4
) (
  input  logic          iCLK,
  input  logic          iWe,
  input  logic [AW-1:0] iAddr,
  input  logic [DW-1:0] iD,
  input  logic [AW-1:0] iRaddr,
  output logic [DW-1:0] oQ
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge iCLK) begin
    if (iWe) mem_q[iAddr] <= iD;
  end

  assign oQ = mem_q[iRaddr];
endmodule

// File: rtl/relu_maxpool2x2.sv
// ReLU + 2x2/stride-2 max-pool + shift/saturate requantization on a raster conv stream.
module relu_maxpool2x2
  import conv_pkg::*;
#(
  parameter int BW_IN  = BW_CONV,
  parameter int BW_OUT = BW_ACT,
  parameter int IMG_W  = CONV_W,
  parameter int IMG_H  = CONV_W,
  parameter int SHIFT  = REQ_SHIFT
) (
  input  logic                     iCLK,
  input  logic                     iRSTn,
  input  logic                     iValid,
  input  logic signed [BW_IN-1:0]  iY,
  output logic                     oValid,
  output logic signed [BW_OUT-1:0] oP,
  output logic                     oFrameDone
);
  localparam int UW  = BW_IN - 1;
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LBD = IMG_W / POOL;
  localparam int AW  = (LBD > 1) ? $clog2(LBD) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [UW-1:0] P_LIM    = UW'((1 << (BW_OUT - 1)) - 1);

  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [UW-1:0]     hreg_q, hreg_d;
  logic              vld_q, done_q;
  logic [BW_OUT-1:0] p_q, p_d;

  logic [UW-1:0] r, hmax, lb_q, pmax, q;
  logic [AW-1:0] lb_addr;
  logic          col_last, row_last, lb_we, fire;

  // Non-negative after ReLU, so the sign bit is dropped from here on.
  assign r        = iY[BW_IN-1] ? '0 : iY[UW-1:0];
  assign hmax     = (hreg_q > r) ? hreg_q : r;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign lb_addr  = AW'(col_q >> 1);
  assign lb_we    = iValid & col_q[0] & ~row_q[0];
  assign fire     = iValid & col_q[0] & row_q[0];

  pool_linebuf #(.DEPTH(LBD), .DW(UW), .AW(AW)) u_lb (
    .iCLK  (iCLK),
    .iWe   (lb_we),
    .iAddr (lb_addr),
    .iD    (hmax),
    .iRaddr(lb_addr),
    .oQ    (lb_q)
  );

  assign pmax = (lb_q > hmax) ? lb_q : hmax;
  assign q    = pmax >> SHIFT;
  assign p_d  = (q > P_LIM) ? BW_OUT'(P_LIM) : BW_OUT'(q);

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    hreg_d = hreg_q;
    if (iValid) begin
      if (!col_q[0]) hreg_d = r;
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last) row_d = row_last ? '0 : row_q + RW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTn) begin
      col_q  <= '0;
      row_q  <= '0;
      hreg_q <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      p_q    <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hreg_q <= hreg_d;
      vld_q  <= fire;
      done_q <= fire & col_last & row_last;
      if (fire) p_q <= p_d;
    end
  end

  assign oValid     = vld_q;
  assign oFrameDone = done_q;
  assign oP         = p_q;
endmodule

// File: tb/tb_relu_maxpool2x2.sv
// Self-checking bench: directed scenarios plus random gaps against a frame-level pooling model.
module tb_relu_maxpool2x2;
  localparam int W = 28;
  localparam int H = 28;
  localparam int N = W * H;
  localparam int NOUT = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  relu_maxpool2x2_if #(.BW_IN(16), .BW_OUT(8)) bus ();

  relu_maxpool2x2 dut (
    .iCLK      (clk),
    .iRSTn     (rst_n),
    .iValid    (bus.valid),
    .iY        (bus.y),
    .oValid    (bus.ovalid),
    .oP        (bus.p),
    .oFrameDone(bus.frame_done)
  );

  int errors = 0;
  int checks = 0;
  int img [H][W];
  int k = 0;
  int last_p = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int got_q [$];
  int ramp_ref [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int pool_at(input int r, input int c);
    int m;
    m = relu(img[r-1][c-1]);
    if (relu(img[r-1][c]) > m) m = relu(img[r-1][c]);
    if (relu(img[r][c-1]) > m) m = relu(img[r][c-1]);
    if (relu(img[r][c]) > m) m = relu(img[r][c]);
    m = m >> 4;
    return (m > 127) ? 127 : m;
  endfunction

  task automatic step(input logic v, input logic signed [15:0] y);
    int ev, ep, ed, r, c;
    bus.valid = v;
    bus.y = y;
    @(posedge clk);
    #1;
    ev = 0; ep = last_p; ed = 0;
    if (!rst_n) begin
      k = 0; last_p = 0; ep = 0;
    end else if (v) begin
      r = k / W; c = k % W;
      img[r][c] = int'(y);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        ev = 1; ep = pool_at(r, c); ed = (k == N - 1) ? 1 : 0;
      end
      k = (k + 1) % N;
    end
    chk("oValid", int'(bus.ovalid), ev);
    chk("oP", int'(bus.p), ep);
    chk("oFrameDone", int'(bus.frame_done), ed);
    if (bus.ovalid) begin
      out_cnt++;
      got_q.push_back(int'(bus.p));
    end
    if (bus.frame_done) done_cnt++;
    last_p = ep;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step(1'b1, 16'sd1000);
    rst_n = 1'b1;
    out_cnt = 0; done_cnt = 0; got_q.delete();
  endtask

  task automatic end_frame(input string tag);
    chk({tag, "_outcount"}, out_cnt, NOUT);
    chk({tag, "_donecount"}, done_cnt, 1);
    out_cnt = 0; done_cnt = 0;
  endtask

  task automatic frame_const(input int y);
    for (int i = 0; i < N; i++) step(1'b1, 16'(y));
  endtask

  task automatic frame_ramp(input int maxgap);
    for (int i = 0; i < N; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) step(1'b0, 16'($urandom));
      step(1'b1, 16'(i));
    end
  endtask

  task automatic cmp_ramp(input string tag);
    chk({tag, "_len"}, got_q.size(), ramp_ref.size());
    for (int i = 0; i < NOUT && i < got_q.size(); i++) chk(tag, got_q[i], ramp_ref[i]);
    got_q.delete();
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.y = '0;
    // 1: reset with live-looking input
    do_reset(3);

    // 2: single non-zero first window
    for (int i = 0; i < N; i++) begin
      int y;
      case (i)
        0: y = -5;
        1: y = 48;
        W: y = 160;
        W + 1: y = -100;
        default: y = 0;
      endcase
      step(1'b1, 16'(y));
    end
    end_frame("window");
    chk("window_first", (got_q.size() > 0) ? got_q[0] : -1, 10);
    begin
      int s = 0;
      for (int i = 1; i < got_q.size(); i++) s += got_q[i];
      chk("window_rest_zero", s, 0);
    end
    got_q.delete();

    // 3: all-negative frame
    frame_const(-32768);
    end_frame("neg");
    got_q.delete();

    // 4: saturation frames
    frame_const(32767);
    end_frame("sat_max");
    chk("sat_max_val", got_q[NOUT-1], 127);
    got_q.delete();
    frame_const(2032);
    end_frame("sat_2032");
    chk("sat_2032_val", got_q[0], 127);
    got_q.delete();
    frame_const(2015);
    end_frame("sat_2015");
    chk("sat_2015_val", got_q[0], 125);
    got_q.delete();

    // 5: ramp gap-free as reference, then with random gaps
    frame_ramp(0);
    end_frame("ramp");
    ramp_ref = got_q;
    got_q.delete();
    chk("ramp_first", ramp_ref[0], 1);
    chk("ramp_last", ramp_ref[NOUT-1], 48);
    frame_ramp(5);
    end_frame("gap");
    cmp_ramp("gap_seq");

    // 6: reset inside row 13, then two back-to-back frames
    for (int i = 0; i < 13 * W + 5; i++) step(1'b1, 16'(i + 300));
    do_reset(2);
    frame_ramp(0);
    end_frame("b2b_a");
    cmp_ramp("b2b_a_seq");
    frame_ramp(0);
    end_frame("b2b_b");
    cmp_ramp("b2b_b_seq");
    repeat (3) step(1'b0, 16'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
